// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions: instruction width, word addressing and the
// IF/ID bundle reused by later pipeline stages.
package cpu_defs;

  localparam int INSTR_W    = 32;
  localparam int WORD_SHIFT = 2;

  // Bubble encoding: sll $0,$0,0
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] pc4;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } ifid_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// Generic pipeline register with hold and bubble controls.
// A flush turns the slot into a bubble but keeps pc4.
module ifid_reg
  import cpu_defs::*;
#(
  parameter logic [INSTR_W-1:0] NOP = NOP_WORD
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);

  ifid_t slot_q;

  // Flush wins over hold so a redirect always inserts exactly one bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q.pc4   <= '0;
      slot_q.instr <= NOP;
      slot_q.valid <= 1'b0;
    end else if (flush) begin
      slot_q.instr <= NOP;
      slot_q.valid <= 1'b0;
    end else if (!hold) begin
      slot_q <= d;
    end
  end

  assign q = slot_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, fault detection and
// the IF/ID register. imem_addr comes straight from the PC flop.
module fetch_stage
  import cpu_defs::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                 IMEM_WORDS = 128,
  parameter logic [INSTR_W-1:0] NOP_WORD   = cpu_defs::NOP_WORD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] ifid_pc4,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] fetch_count,
  output logic               fetch_fault
);

  // Byte bound held in 33 bits so a full 4 GiB memory still compares correctly.
  localparam logic [INSTR_W:0] IMEM_BYTES = (INSTR_W+1)'(IMEM_WORDS) << WORD_SHIFT;
  localparam logic [INSTR_W-1:0] WORD_MASK = ~((INSTR_W'(1) << WORD_SHIFT) - INSTR_W'(1));

  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] count_q, count_d;
  logic               fault_q, fault_d;
  logic [INSTR_W-1:0] pc_plus4;
  logic               bad_fetch;
  logic               advance;
  ifid_t              fetch_d, ifid_q;

  assign pc_plus4  = pc_q + 32'd4;
  assign bad_fetch = ((pc_q & ~WORD_MASK) != '0) || ({1'b0, pc_q} >= IMEM_BYTES);
  assign advance   = !redirect && !stall;

  // Next-state selection; redirect overrides stall and is force-aligned.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    fault_d = fault_q;
    if (redirect) begin
      pc_d = redirect_pc & WORD_MASK;
    end else if (!stall) begin
      pc_d = pc_plus4;
      if (bad_fetch) begin
        fault_d = 1'b1;
      end else begin
        count_d = count_q + 32'd1;
      end
    end
  end

  // PC, commit counter and sticky fault flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  // Word presented to IF/ID; a bad fetch becomes a bubble.
  always_comb begin
    fetch_d.pc4   = pc_plus4;
    fetch_d.instr = bad_fetch ? NOP_WORD : imem_instr;
    fetch_d.valid = !bad_fetch;
  end

  ifid_reg #(.NOP(NOP_WORD)) u_ifid (
    .clk   (clk),
    .rst   (rst),
    .hold  (stall),
    .flush (redirect),
    .d     (fetch_d),
    .q     (ifid_q)
  );

  assign imem_addr   = pc_q;
  assign ifid_pc4    = ifid_q.pc4;
  assign ifid_instr  = ifid_q.instr;
  assign ifid_valid  = ifid_q.valid;
  assign fetch_count = count_q;
  assign fetch_fault = fault_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined MIPS core. Holds the program counter and presents it to the combinational instruction memory. Captures the returned word into the IF/ID pipeline register. Supports stall (hazard unit), redirect (branch/jump resolved in ID) and bubble insertion. Sits directly upstream of instruction memory and downstream of the hazard/branch logic.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_WORDS, 128, instruction memory depth in 32-bit words; byte addresses >= 4*IMEM_WORDS are out of range.
NOP_WORD, 32'h0000_0000, encoding inserted as a bubble (sll $0,$0,0).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
stall  in  1  hazard unit: hold PC and IF/ID.
redirect  in  1  branch taken or jump in ID; load redirect_pc and squash the fetched word.
redirect_pc  in  32  target byte address.
imem_addr  out  32  byte address to instruction memory; equals the PC register.
imem_instr  in  32  word returned combinationally by instruction memory for imem_addr.
ifid_pc4  out  32  IF/ID: PC+4 of the captured instruction.
ifid_instr  out  32  IF/ID: captured instruction word.
ifid_valid  out  1  IF/ID: 1 = real instruction, 0 = bubble.
fetch_count  out  32  number of instructions committed into IF/ID with valid=1.
fetch_fault  out  1  sticky flag: a fetch was attempted at a misaligned or out-of-range PC.

Behaviour:
- All state updates on the rising edge of clk. Priority order: rst > redirect > stall > normal.
- Reset values:
  - PC = RESET_PC; imem_addr = RESET_PC.
  - ifid_pc4 = 0; ifid_instr = NOP_WORD; ifid_valid = 0.
  - fetch_count = 0; fetch_fault = 0.
- Reset mid-operation discards all in-flight state. The first valid IF/ID capture occurs on the second rising edge after rst deasserts:
  - Edge 1 (rst still high): loads RESET_PC.
  - Edge 2: captures mem[RESET_PC].
- imem_addr is driven combinationally from the PC register. There is no extra latency: the word at PC is captured at the edge that ends the cycle.
- Normal (no stall, no redirect):
  - PC <= PC+4, modulo 2^32; wrap-around from 32'hFFFF_FFFC to 0 is permitted.
  - ifid_instr <= imem_instr, ifid_pc4 <= PC+4, ifid_valid <= 1.
  - fetch_count increments by 1.
- Stall (redirect=0): PC, ifid_*, fetch_count all hold their values.
- Redirect (regardless of stall):
  - PC <= {redirect_pc[31:2], 2'b00}.
  - ifid_instr <= NOP_WORD, ifid_valid <= 0; ifid_pc4 holds.
  - fetch_count unchanged.
  - Net effect: the wrong-path word is squashed with exactly one bubble.
- Fault check. A fetch is bad if PC[1:0] != 0 or PC >= 4*IMEM_WORDS. In the normal path with a bad PC:
  - Capture NOP_WORD with ifid_valid=0, and set fetch_fault to 1.
  - PC still advances.
  - fetch_fault clears only on rst.
  - A misaligned PC is reachable only via RESET_PC, because redirect is force-aligned.
- fetch_count wraps modulo 2^32 and saturates nowhere.
- No combinational path from stall or redirect to imem_addr.

Decomposition:
- Shared package cpu_defs:
  - NOP_WORD, instruction width (32) and the byte-per-word shift (2).
  - A typedef for the IF/ID bundle {pc4, instr, valid}, reused by the ID stage.
- One natural sub-module, ifid_reg: the IF/ID pipeline register with hold (stall) and bubble (flush) controls. It is reused as a pattern for the later ID/EX, EX/MEM and MEM/WB registers.
- The PC register and next-PC mux stay in fetch_stage.

Test Plan:
- Reset then free-run; memory loaded with mem[0]=32'h2008_0005, mem[1]=32'h2009_000A. Required response:
  - Second edge after rst low: ifid_instr=32'h2008_0005, ifid_pc4=4, valid=1.
  - Third edge: ifid_instr=32'h2009_000A, ifid_pc4=8.
  - fetch_count=2.
- Stall held 3 cycles at PC=8 -> imem_addr stays 8; ifid_* and fetch_count unchanged. On release, the next edge captures mem[2] with ifid_pc4=12.
- Redirect with redirect_pc=32'h0000_0040 while PC=12. Required response:
  - Next edge: PC=0x40, ifid_valid=0, ifid_instr=0, count unchanged.
  - Following edge: captures mem[16], ifid_pc4=0x44.
- Redirect and stall asserted together, redirect_pc=32'h0000_0023 -> PC=0x20 (low bits forced to 0), bubble inserted, and the stall is ignored for that edge.
- Redirect to 32'h0000_0200 (IMEM_WORDS=128). Required response:
  - Next edge: PC=0x200.
  - Following edge: bubble captured, fetch_fault=1, PC=0x204.
  - Fault stays 1 after a later redirect to 0, and clears only when rst is asserted.
- rst asserted mid-run (PC=0x10, count=4) -> next edge: PC=0, ifid_valid=0, ifid_instr=0, fetch_count=0, fetch_fault=0.
